// File: rtl/scic_io_responder.sv
// scic_io_responder: peripheral side of the SCIC IN/OUT port accesses.
// Holds the LED output register and conditions the board switches with a
// synchronizer, a debouncer and a change flag that can raise an interrupt.
// CPU strobes are level signals. Each strobe assertion produces exactly one
// transaction, acknowledged by a single-cycle io_ready pulse.
module scic_io_responder #(
   parameter int unsigned BUS_WIDTH       = 8,
   parameter int unsigned IO_WIDTH        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_WIDTH       = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           io_addr,
   input  logic [BUS_WIDTH-1:0] io_wdata,
   input  logic                 io_wr,
   input  logic                 io_rd,
   output logic [BUS_WIDTH-1:0] io_rdata,
   output logic                 io_ready,
   output logic                 irq,
   input  logic [IO_WIDTH-1:0]  switches,
   output logic [IO_WIDTH-1:0]  LEDs
);

   // Counter must be able to hold DEBOUNCE_CYCLES itself.
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_CYCLES);

   localparam logic [1:0] ADDR_LED    = 2'd0;
   localparam logic [1:0] ADDR_SW     = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CNT    = 2'd3;

   typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;

   state_e                 state;

   logic [IO_WIDTH-1:0]    sync_meta;
   logic [IO_WIDTH-1:0]    sync;
   logic [IO_WIDTH-1:0]    sync_prev;
   logic [IO_WIDTH-1:0]    stable;
   logic [DB_W-1:0]        db_cnt;
   logic [DB_W-1:0]        db_next;
   logic                   db_hit;

   logic                   chg_flag;
   logic                   irq_en;
   logic [CNT_WIDTH-1:0]   chg_cnt;

   logic                   access;
   logic                   wr_access;
   logic [BUS_WIDTH-1:0]   rd_mux;

   // Upper write-data bits have no destination in this register map.
   logic                   unused_wdata;
   assign unused_wdata = ^io_wdata;

   // A transaction starts only from IDLE. A write wins over a read.
   assign access    = (state == StIdle) && (io_wr || io_rd);
   assign wr_access = access && io_wr;

   // Two-flop synchronizer, plus last cycle's synchronized value for the debouncer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_meta <= '0;
         sync      <= '0;
         sync_prev <= '0;
      end else begin
         sync_meta <= switches;
         sync      <= sync_meta;
         sync_prev <= sync;
      end
   end

   // Debounce next-state: count consecutive identical samples that differ from stable.
   always_comb begin
      db_next = db_cnt;
      db_hit  = 1'b0;
      if (sync == stable) begin
         db_next = '0;
      end else begin
         if (sync == sync_prev) begin
            db_next = db_cnt + DB_W'(1);
         end else begin
            db_next = DB_W'(1);
         end
         if (db_next == DB_TARGET) begin
            db_hit  = 1'b1;
            db_next = '0;
         end
      end
   end

   // Debounce counter and accepted switch value.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         db_cnt <= '0;
         stable <= '0;
      end else begin
         db_cnt <= db_next;
         if (db_hit) begin
            stable <= sync;
         end
      end
   end

   // Read data is taken from pre-edge register state.
   always_comb begin
      rd_mux = '0;
      case (io_addr)
         ADDR_LED:    rd_mux[IO_WIDTH-1:0]  = LEDs;
         ADDR_SW:     rd_mux[IO_WIDTH-1:0]  = stable;
         ADDR_STATUS: rd_mux[1:0]           = {irq_en, chg_flag};
         ADDR_CNT:    rd_mux[CNT_WIDTH-1:0] = chg_cnt;
         default:     rd_mux                = '0;
      endcase
   end

   // LED output register, written through LED_OUT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         LEDs <= '0;
      end else if (wr_access && (io_addr == ADDR_LED)) begin
         LEDs <= io_wdata[IO_WIDTH-1:0];
      end
   end

   // Change flag (set beats write-1-to-clear), interrupt enable and registered irq.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chg_flag <= 1'b0;
         irq_en   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         irq <= chg_flag & irq_en;
         if (db_hit) begin
            chg_flag <= 1'b1;
         end else if (wr_access && (io_addr == ADDR_STATUS) && io_wdata[0]) begin
            chg_flag <= 1'b0;
         end
         if (wr_access && (io_addr == ADDR_STATUS)) begin
            irq_en <= io_wdata[1];
         end
      end
   end

   // Change counter. A clear and an increment in the same cycle leave it at 1.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chg_cnt <= '0;
      end else if (wr_access && (io_addr == ADDR_CNT)) begin
         chg_cnt <= db_hit ? CNT_WIDTH'(1) : '0;
      end else if (db_hit) begin
         chg_cnt <= chg_cnt + CNT_WIDTH'(1);
      end
   end

   // Handshake FSM with registered io_ready/io_rdata.
   // HOLD waits for both strobes to drop so that a held strobe gives one transaction.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= StIdle;
         io_ready <= 1'b0;
         io_rdata <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               io_ready <= 1'b0;
               io_rdata <= '0;
               if (access) begin
                  state    <= StAck;
                  io_ready <= 1'b1;
                  io_rdata <= io_wr ? '0 : rd_mux;
               end
            end
            StAck: begin
               io_ready <= 1'b0;
               io_rdata <= '0;
               state    <= StHold;
            end
            StHold: begin
               io_ready <= 1'b0;
               io_rdata <= '0;
               if (!io_wr && !io_rd) begin
                  state <= StIdle;
               end
            end
            default: begin
               io_ready <= 1'b0;
               io_rdata <= '0;
               state    <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scic_io_responder.sv
// Bench for scic_io_responder. A behavioural model predicts the outputs each cycle.
// Directed transactions with literal expectations pin the model.
module tb_scic_io_responder;

   localparam int unsigned BW  = 8;
   localparam int unsigned IOW = 4;
   localparam int unsigned DC  = 4;
   localparam int unsigned CW  = 8;

   logic           clock;
   logic           reset;
   logic [1:0]     io_addr;
   logic [BW-1:0]  io_wdata;
   logic           io_wr;
   logic           io_rd;
   logic [BW-1:0]  io_rdata;
   logic           io_ready;
   logic           irq;
   logic [IOW-1:0] switches;
   logic [IOW-1:0] LEDs;

   int checks = 0;
   int passes = 0;

   scic_io_responder #(
      .BUS_WIDTH       (BW),
      .IO_WIDTH        (IOW),
      .DEBOUNCE_CYCLES (DC),
      .CNT_WIDTH       (CW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_wr    (io_wr),
      .io_rd    (io_rd),
      .io_rdata (io_rdata),
      .io_ready (io_ready),
      .irq      (irq),
      .switches (switches),
      .LEDs     (LEDs)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         passes++;
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [IOW-1:0] m_pin1 = '0;      // pin as sampled one edge ago
   logic [IOW-1:0] m_pin2 = '0;      // pin as sampled two edges ago (the synchronized value)
   logic [IOW-1:0] m_last = '0;
   int unsigned    m_run = 1;        // length of the current run of identical synchronized samples
   logic [IOW-1:0] m_stable = '0;
   logic [IOW-1:0] m_leds = '0;
   logic           m_flag = 1'b0;
   logic           m_en = 1'b0;
   logic           m_irq = 1'b0;
   logic [CW-1:0]  m_cnt = '0;
   logic           m_ready = 1'b0;
   logic [BW-1:0]  m_rdata = '0;
   logic           m_busy = 1'b0;
   int unsigned    m_age = 0;

   task automatic model_reset();
      m_pin1 = '0; m_pin2 = '0; m_last = '0; m_run = 1;
      m_stable = '0; m_leds = '0; m_flag = 1'b0; m_en = 1'b0; m_irq = 1'b0;
      m_cnt = '0; m_ready = 1'b0; m_rdata = '0; m_busy = 1'b0; m_age = 0;
   endtask

   task automatic model_step();
      logic [IOW-1:0] s;
      logic           hit;
      logic           acc;
      logic           strobe;
      logic [BW-1:0]  rv;
      s = m_pin2;
      m_run = (s == m_last) ? m_run + 1 : 1;
      m_last = s;
      hit = (s != m_stable) && (m_run >= DC);
      strobe = io_wr || io_rd;
      acc = !m_busy && strobe;
      rv = '0;
      case (io_addr)
         2'd0: rv[IOW-1:0] = m_leds;
         2'd1: rv[IOW-1:0] = m_stable;
         2'd2: rv[1:0] = {m_en, m_flag};
         default: rv[CW-1:0] = m_cnt;
      endcase
      m_irq = m_flag & m_en;
      m_ready = acc;
      m_rdata = (acc && !io_wr) ? rv : '0;
      if (acc && io_wr) begin
         case (io_addr)
            2'd0: m_leds = io_wdata[IOW-1:0];
            2'd2: begin
               if (io_wdata[0]) m_flag = 1'b0;
               m_en = io_wdata[1];
            end
            2'd3: m_cnt = '0;
            default: ;
         endcase
      end
      if (hit) begin
         m_stable = s;
         m_flag = 1'b1;
         m_cnt = m_cnt + 8'd1;
      end
      if (acc) begin
         m_busy = 1'b1;
         m_age = 0;
      end else if (m_busy) begin
         if (m_age >= 1 && !strobe) m_busy = 1'b0;
         m_age++;
      end
      m_pin2 = m_pin1;
      m_pin1 = switches;
   endtask

   initial begin
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) model_reset();
         else model_step();
      end
   end

   // Cycle-by-cycle compare, away from the active edge.
   initial begin
      forever begin
         @(negedge clock);
         check("ready", 32'(io_ready), 32'(m_ready));
         check("irq", 32'(irq), 32'(m_irq));
         check("leds", 32'(LEDs), 32'(m_leds));
         if (m_ready) check("rdata", 32'(io_rdata), 32'(m_rdata));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic access(input logic [1:0] a, input logic [BW-1:0] d, input logic w,
                         input logic r, output logic [BW-1:0] rd_out);
      logic got;
      step(1);
      io_addr = a; io_wdata = d; io_wr = w; io_rd = r;
      got = 1'b0;
      rd_out = '0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         if (io_ready) begin
            got = 1'b1;
            rd_out = io_rdata;
         end
      end
      check("ready_seen", 32'(got), 32'd1);
      step(1);
      io_wr = 1'b0; io_rd = 1'b0;
   endtask

   task automatic read_check(input logic [1:0] a, input logic [BW-1:0] exp, input string name);
      logic [BW-1:0] v;
      access(a, '0, 1'b0, 1'b1, v);
      check(name, 32'(v), 32'(exp));
   endtask

   task automatic write(input logic [1:0] a, input logic [BW-1:0] d);
      logic [BW-1:0] v;
      access(a, d, 1'b1, 1'b0, v);
   endtask

   initial begin
      int            pulses;
      logic          got;
      logic [BW-1:0] v;

      reset = 1'b0; io_addr = '0; io_wdata = '0; io_wr = 1'b0; io_rd = 1'b0;
      switches = 4'b1010;
      repeat (3) @(posedge clock);
      #2;
      check("rst_leds", 32'(LEDs), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_ready", 32'(io_ready), 32'd0);
      check("rst_rdata", 32'(io_rdata), 32'd0);
      reset = 1'b1;

      // Accepted at the 2nd edge after release, before the switch value can settle.
      read_check(2'd1, 8'h00, "sw_early");
      step(8);
      read_check(2'd1, 8'h0A, "sw_after_reset");
      read_check(2'd2, 8'h01, "status_after_reset");
      read_check(2'd3, 8'h01, "cnt_after_reset");

      // LED write
      write(2'd0, 8'hA5);
      check("led_write", 32'(LEDs), 32'h5);
      read_check(2'd0, 8'h05, "led_read");

      // Bring switches to 0, then a 3-cycle glitch that must be rejected.
      switches = 4'b0000;
      step(10);
      read_check(2'd3, 8'h02, "cnt_to_zero");
      switches = 4'b0011;
      step(3);
      switches = 4'b0000;
      step(10);
      read_check(2'd1, 8'h00, "sw_glitch");
      read_check(2'd3, 8'h02, "cnt_glitch");

      // Clean edge. A read accepted 6 edges after the pin change still sees the old value.
      switches = 4'b0011;
      step(4);
      read_check(2'd1, 8'h00, "sw_edge6_old");
      read_check(2'd1, 8'h03, "sw_settled");
      read_check(2'd3, 8'h03, "cnt_settled");

      // Interrupt
      write(2'd2, 8'h01);
      write(2'd2, 8'h02);
      check("irq_idle", 32'(irq), 32'd0);
      switches = 4'b0111;
      step(12);
      check("irq_set", 32'(irq), 32'd1);
      read_check(2'd2, 8'h03, "status_flag_en");
      write(2'd2, 8'h03);
      step(2);
      check("irq_cleared", 32'(irq), 32'd0);
      read_check(2'd2, 8'h02, "status_en_kept");

      // Held write strobe on the read-only SW_IN register
      step(1);
      io_addr = 2'd1; io_wdata = 8'hFF; io_wr = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (io_ready) pulses++;
      end
      step(1);
      io_wr = 1'b0;
      check("held_pulses", 32'(pulses), 32'd1);
      read_check(2'd1, 8'h07, "sw_write_ignored");

      // Read and write together: treated as a write
      access(2'd0, 8'h0F, 1'b1, 1'b1, v);
      check("collide_rdata", 32'(v), 32'd0);
      check("collide_leds", 32'(LEDs), 32'hF);

      // Reset during ACK, with the read strobe held across release
      step(1);
      io_addr = 2'd0; io_rd = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         if (io_ready) got = 1'b1;
      end
      check("mid_ack_seen", 32'(got), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_ready", 32'(io_ready), 32'd0);
      check("mid_rst_leds", 32'(LEDs), 32'd0);
      step(2);
      reset = 1'b1;
      pulses = 0;
      v = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (io_ready) begin
            pulses++;
            v = io_rdata;
         end
      end
      check("post_rst_pulses", 32'(pulses), 32'd1);
      check("post_rst_rdata", 32'(v), 32'd0);
      step(1);
      io_rd = 1'b0;
      step(3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
